mcd_cdc_stream: RTL

Mega-CD-side sector streamer: the consumer end of the host sector path. The host fills a 2352-byte sector buffer through the CDC window and pulses a sector-ready command. This block then generates the 75 Hz CDD frame timing and fires the sub-CPU interrupt at the configured phase. It reads the buffer back byte by byte and delivers the bytes to the CDC decoder at a paced rate, reporting completion and overrun status to the host.

---
 rtl/mcd_cdc_stream_if.sv | 26 ++
 rtl/mcd_cdc_stream.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mcd_cdc_stream_if.sv
// Sector-streamer bus: host command/status, sector buffer read port and CDC byte output.
// Latency: n/a (signal bundle only).
// Backpressure: none; the CDC side is paced by the streamer and the buffer read is fixed-latency.
interface mcd_cdc_stream_if;
    logic        sec_rdy;   // host: sector written, one-cycle pulse
    logic        stat_clr;  // host: clear sec_done/overrun, one-cycle pulse
    logic [11:0] pha;       // irq phase in units after frame start, 0 = 350
    logic [11:0] buf_addr;  // sector buffer read address
    logic [7:0]  buf_dat;   // buffer data, one cycle after buf_addr
    logic [7:0]  cdc_dat;   // byte to CDC decoder
    logic        cdc_wr;    // write strobe for cdc_dat
    logic        cdd_irq;   // per-frame sub-CPU interrupt pulse
    logic        busy;      // transfer in progress
    logic        sec_done;  // sticky: last sector delivered
    logic        overrun;   // sticky: request dropped

    // master = host/buffer side, slave = streamer
    modport master (
        output sec_rdy, stat_clr, pha, buf_dat,
        input  buf_addr, cdc_dat, cdc_wr, cdd_irq, busy, sec_done, overrun
    );
    modport slave (
        input  sec_rdy, stat_clr, pha, buf_dat,
        output buf_addr, cdc_dat, cdc_wr, cdd_irq, busy, sec_done, overrun
    );
endinterface

// File: rtl/mcd_cdc_stream.sv
// Mega-CD sector streamer: 75 Hz frame timing, phase irq, paced sector readout to the CDC.
// Latency: first byte strobe 2 cycles after the phase point, then one byte every BYTE_DIV cycles.
// Backpressure: none; a request while pending/busy is dropped and flagged as overrun.
// Ports: clk/rst plain; everything else on the slave modport of mcd_cdc_stream_if.
module mcd_cdc_stream #(
    parameter int SECTOR_LEN = 2352,
    parameter int FRAME_DIV  = 666667,
    parameter int PHA_UNIT   = 64,
    parameter int BYTE_DIV   = 8
) (
    input  logic            clk,
    input  logic            rst,
    mcd_cdc_stream_if.slave bus
);
    localparam int FW = $clog2(FRAME_DIV);
    localparam int PW = (PHA_UNIT > 1) ? $clog2(PHA_UNIT) : 1;
    localparam int UW = $clog2(FRAME_DIV / PHA_UNIT + 1);
    localparam int GW = (BYTE_DIV > 2) ? $clog2(BYTE_DIV) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, DATA, GAP, DONE} state_t;

    logic [FW-1:0] fcnt;
    logic [PW-1:0] pcnt;
    logic [UW-1:0] ucnt;
    logic [11:0]   pha_lat;
    logic          phase_pt;

    state_t        state;
    state_t        state_nxt;
    logic [11:0]   bidx;
    logic [GW-1:0] gcnt;
    logic [7:0]    cdc_q;
    logic          pending;
    logic          sec_done_q;
    logic          overrun_q;
    logic          busy_i;
    logic          start;
    logic          step;
    logic          last_byte;

    // Frame timing. pcnt/ucnt restart with the frame so that ucnt == fcnt / PHA_UNIT
    // and the phase point lands exactly on fcnt == pha_eff * PHA_UNIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt    <= '0;
            pcnt    <= '0;
            ucnt    <= '0;
            pha_lat <= 12'd350;
        end else begin
            if (fcnt == FW'(FRAME_DIV - 1)) begin
                fcnt <= '0;
                pcnt <= '0;
                ucnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
                if (pcnt == PW'(PHA_UNIT - 1)) begin
                    pcnt <= '0;
                    ucnt <= ucnt + 1'b1;
                end else begin
                    pcnt <= pcnt + 1'b1;
                end
            end
            // Phase is taken once per frame so a mid-frame write cannot double-fire.
            if (fcnt == '0) begin
                pha_lat <= (bus.pha == 12'd0) ? 12'd350 : bus.pha;
            end
        end
    end

    // pha_lat is never 0, so the frame-start cycle cannot match; phases beyond the
    // last unit of the frame simply never match.
    assign phase_pt  = (pcnt == '0) && (32'(ucnt) == 32'(pha_lat));
    assign start     = (state == IDLE) && phase_pt && pending;
    assign last_byte = (bidx == 12'(SECTOR_LEN - 1));

    // step: this cycle ends the current byte slot. With BYTE_DIV == 2 the slot is
    // only LOAD+DATA, so the gap state is skipped entirely.
    always_comb begin
        step = 1'b0;
        if (state == DATA) begin
            step = (BYTE_DIV == 2);
        end else if (state == GAP) begin
            step = (gcnt <= GW'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = DATA;
            DATA:    state_nxt = step ? (last_byte ? DONE : LOAD) : GAP;
            GAP:     if (step) state_nxt = last_byte ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Buffer data is presented to the CDC in the same cycle it arrives so the strobe
    // and data line up; cdc_q then holds the byte until the next write.
    always_comb begin
        busy_i      = (state == LOAD) || (state == DATA) || (state == GAP);
        bus.cdc_wr  = (state == DATA);
        bus.cdc_dat = (state == DATA) ? bus.buf_dat : cdc_q;
    end

    assign bus.busy     = busy_i;
    assign bus.buf_addr = bidx;
    assign bus.cdd_irq  = phase_pt;
    assign bus.sec_done = sec_done_q;
    assign bus.overrun  = overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bidx  <= '0;
            gcnt  <= '0;
            cdc_q <= '0;
        end else begin
            if (start) begin
                bidx <= '0;
            end else if (step && !last_byte) begin
                bidx <= bidx + 1'b1;
            end
            // Gap counter covers the BYTE_DIV-2 cycles left after LOAD and DATA.
            if (state == DATA) begin
                gcnt  <= GW'(BYTE_DIV - 2);
                cdc_q <= bus.buf_dat;
            end else if (state == GAP) begin
                gcnt <= gcnt - 1'b1;
            end
        end
    end

    // Status flags: setting events take priority over clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending    <= 1'b0;
            overrun_q  <= 1'b0;
            sec_done_q <= 1'b0;
        end else begin
            if (bus.sec_rdy && !(pending || busy_i)) begin
                pending <= 1'b1;
            end else if (start) begin
                pending <= 1'b0;
            end

            if (bus.sec_rdy && (pending || busy_i)) begin
                overrun_q <= 1'b1;
            end else if (bus.stat_clr) begin
                overrun_q <= 1'b0;
            end

            if (state_nxt == DONE) begin
                sec_done_q <= 1'b1;
            end else if (bus.sec_rdy || bus.stat_clr) begin
                sec_done_q <= 1'b0;
            end
        end
    end
endmodule
